// File: rtl/ireg_wport_arbiter.sv
// ireg_wport_arbiter
// Arbitrates the single ireg write port between requester A (ALU) and B (load
// unit). Also holds the busy scoreboard for in-flight destinations; the issue
// stage uses it for hazard detection through two combinational query ports.
module ireg_wport_arbiter #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic [AW-1:0] rw,
  output logic [DW-1:0] dw,
  output logic          we,
  input  logic          rsv_valid,
  input  logic [AW-1:0] rsv_addr,
  output logic          rsv_conflict,
  input  logic [AW-1:0] q0_addr,
  output logic          q0_busy,
  input  logic [AW-1:0] q1_addr,
  output logic          q1_busy
);

  localparam int NR = 1 << AW;

  // 0 = A has priority when both request, 1 = B has priority
  logic          prio_b;
  logic [NR-1:0] busy;
  logic [NR-1:0] clr_mask;
  logic [NR-1:0] set_mask;
  logic          both_valid;
  logic          commit_hits_rsv;

  assign both_valid = a_valid & b_valid;

  // A requester that is alone always wins; a tie goes to the priority pointer.
  assign a_ready = ~stall & a_valid & (~b_valid | ~prio_b);
  assign b_ready = ~stall & b_valid & (~a_valid |  prio_b);

  // Queries see the committed scoreboard only; same-cycle updates are not forwarded.
  assign q0_busy = busy[q0_addr];
  assign q1_busy = busy[q1_addr];

  assign commit_hits_rsv = we & (rw == rsv_addr);

  // Round-robin pointer: moves to the loser only when there was contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_b <= 1'b0;
    end else if (~stall & both_valid) begin
      prio_b <= a_ready;
    end
  end

  // Register the granted write so ireg sees rw/dw/we one cycle after the grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      we <= 1'b0;
      rw <= '0;
      dw <= '0;
    end else begin
      we <= a_ready | b_ready;
      if (a_ready) begin
        rw <= a_addr;
        dw <= a_data;
      end else if (b_ready) begin
        rw <= b_addr;
        dw <= b_data;
      end
    end
  end

  // One-hot clear (commit) and set (reserve) masks for this cycle's edge.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (we)        clr_mask[rw]       = 1'b1;
    if (rsv_valid) set_mask[rsv_addr] = 1'b1;
  end

  // Scoreboard update: set applied after clear so a same-address reserve wins.
  // A reserve onto an entry that is being committed this cycle is a fresh
  // producer, not a conflict.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy         <= '0;
      rsv_conflict <= 1'b0;
    end else begin
      busy         <= (busy & ~clr_mask) | set_mask;
      rsv_conflict <= rsv_valid & busy[rsv_addr] & ~commit_hits_rsv;
    end
  end

endmodule

// File: doc/ireg_wport_arbiter.md
Name: ireg_wport_arbiter

Overview:
Shares the single write port of the 64x32 integer register file (ireg) between two writeback requesters: A (ALU) and B (load unit).
- Round-robin arbitration, one grant per cycle, registered drive of rw/dw/we.
- 64-entry busy scoreboard: the issue stage reserves a destination register, and the entry clears when that register's write commits.
- Two combinational busy-query ports, matching ireg's r0/r1 read ports, for hazard detection.

Parameters:
AW, 6, register address width (2^AW registers)
DW, 32, data width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  1 = grant nothing this cycle
a_valid  in  1  requester A has a write pending
a_ready  out  1  A accepted this cycle (combinational)
a_addr  in  AW  A destination register
a_data  in  DW  A write data
b_valid  in  1  requester B has a write pending
b_ready  out  1  B accepted this cycle (combinational)
b_addr  in  AW  B destination register
b_data  in  DW  B write data
rw  out  AW  to ireg rw
dw  out  DW  to ireg dw
we  out  1  to ireg we
rsv_valid  in  1  reserve rsv_addr in scoreboard
rsv_addr  in  AW  register to mark busy
rsv_conflict  out  1  registered pulse: reserve hit an already-busy entry
q0_addr  in  AW  busy query 0
q0_busy  out  1  busy[q0_addr] (combinational)
q1_addr  in  AW  busy query 1
q1_busy  out  1  busy[q1_addr] (combinational)

Behaviour:
- Reset (reset=1 at rising edge) sets:
  - we=0, rw=0, dw=0, rsv_conflict=0
  - all busy bits=0
  - priority pointer = A
  - Reset overrides every other event in that cycle, including a pending reserve or commit.
- Handshake:
  - A requester asserts valid with addr/data and holds all three stable until ready=1 in the same cycle.
  - Transfer occurs on the edge where valid&ready=1.
  - ready is never 1 while valid=0 or stall=1.
- Arbitration (combinational, per cycle, when stall=0):
  - Only one valid: that requester is granted.
  - Both valid: the requester named by the priority pointer is granted.
  - The pointer flips to the non-granted requester only on a cycle where both were valid. Single-requester grants leave it unchanged.
- Write latency, one cycle:
  - Grant in cycle N gives we=1 in cycle N+1, with rw/dw = granted addr/data registered at the end of cycle N.
  - ireg writes at the edge ending cycle N+1.
  - No grant in cycle N gives we=0 in cycle N+1; rw/dw hold their previous values.
  - Back-to-back grants give continuous we=1, one write per cycle.
- Scoreboard, edge ending a cycle:
  - rsv_valid=1 sets busy[rsv_addr].
  - we=1 clears busy[rw]. The clear coincides with ireg latching dw, so busy=0 is never visible before the data is.
  - Reserve and commit to the same address in the same cycle: reserve wins, the bit stays 1 (a new producer was issued).
  - Reserve and commit to different addresses in the same cycle: both take effect.
  - rsv_valid=1 on an address already busy and not being cleared that cycle: the bit stays 1 and rsv_conflict=1 for the next cycle only. A reserve on an address being cleared that cycle is not a conflict.
- Queries: q0_busy/q1_busy read current busy state combinationally. Same-cycle reserve/commit is not forwarded.
- Writes to register 0 are treated like any other address; no hardwired zero.
- The arbiter does no address checking. A/B writes to unreserved registers still commit, and the clear is a no-op.
- Reset asserted mid-transfer drops the registered write: we=0 next cycle and no busy bit survives.

Test Plan:
- Reset → we=0, rw=0, dw=0, rsv_conflict=0; q0_busy=0 for q0_addr=0..63; a_ready=b_ready=0 with both valids low.
- A only, addr=5, data=0x12345678, cycle N → a_ready=1 in N; we=1, rw=5, dw=0x12345678 in N+1; we=0 in N+2.
- Both valid for 4 cycles after reset (A addr 1, B addr 2) → grants A,B,A,B; writes rw=1,2,1,2 on consecutive cycles; the non-granted ready stays 0 and its request holds.
- rsv addr 7 → q0_busy(7)=1 next cycle; A writes 7 → busy stays 1 through the we cycle, 0 after that edge. Reserve 7 twice → rsv_conflict=1 for exactly one cycle.
- Same-cycle reserve of addr 9 and commit to addr 9 → busy[9]=1 afterward, rsv_conflict=0; stall=1 with both valid → no readies, we=0 next cycle, pointer unchanged.
- Reset asserted the cycle after a grant to addr 3 with busy[3]=1 → we=0, busy[3]=0 after reset, pointer back to A.
